// File: rtl/rsa_job_ctrl_if.sv
// rsa_job_ctrl_if: host/datapath control signals of the RSA job controller
interface rsa_job_ctrl_if #(parameter int CNT_W = 16);
  logic enable, abort, err_clr, empty_fifo, nextByte_in, over;
  logic load, running, dp_clear, busy, job_done, timeout_err;
  logic [CNT_W-1:0] job_count;
  logic [2:0] state_dbg;
  modport slave (
    input enable, abort, err_clr, empty_fifo, nextByte_in, over,
    output load, running, dp_clear, busy, job_done, timeout_err, job_count, state_dbg
  );
  modport master (
    output enable, abort, err_clr, empty_fifo, nextByte_in, over,
    input load, running, dp_clear, busy, job_done, timeout_err, job_count, state_dbg
  );
endinterface

// File: rtl/rsa_job_ctrl.sv
// rsa_job_ctrl: sequences one RSA job (load, run, done) with watchdog, abort and job counter
module rsa_job_ctrl #(
  parameter int WordSize    = 32,
  parameter int TIMEOUT_CYC = 2**20,
  parameter int CLEAR_CYC   = 2,
  parameter int CNT_W       = 16
) (
  input logic clk,
  input logic reset,
  rsa_job_ctrl_if.slave ctl
);
  localparam int BYTES = 3*WordSize/8;
  localparam int BC_W  = $clog2(BYTES);
  localparam int WD_W  = $clog2(TIMEOUT_CYC);
  localparam int CL_W  = CLEAR_CYC > 1 ? $clog2(CLEAR_CYC) : 1;
  typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, RUN = 3'd2, DONE = 3'd3, FLUSH = 3'd4} state_t;
  state_t state, nxt;
  logic [BC_W-1:0] byte_cnt;
  logic [WD_W-1:0] wdog;
  logic [CL_W-1:0] clr_cnt;
  logic over_q, over_rise, last_byte, wd_hit, tmo, active;
  always_comb begin
    over_rise = ctl.over & ~over_q;
    last_byte = ctl.nextByte_in && byte_cnt == BC_W'(BYTES-1);
    wd_hit = wdog == WD_W'(TIMEOUT_CYC-1);
    active = state == LOAD || state == RUN;
    tmo = 1'b0;
    nxt = state;
    case (state)
      IDLE:  nxt = (ctl.enable & ~ctl.empty_fifo & ~ctl.timeout_err) ? LOAD : IDLE;
      LOAD:  if (ctl.abort) nxt = FLUSH;
             else if (last_byte) nxt = RUN;
             else if (wd_hit) begin nxt = FLUSH; tmo = 1'b1; end
      RUN:   if (ctl.abort) nxt = FLUSH;
             else if (over_rise) nxt = DONE;
             else if (wd_hit) begin nxt = FLUSH; tmo = 1'b1; end
      DONE:  nxt = IDLE;
      FLUSH: nxt = clr_cnt == CL_W'(CLEAR_CYC-1) ? IDLE : FLUSH;
      default: nxt = IDLE;
    endcase
  end
  // outputs are decoded from the next state so they line up with the state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      byte_cnt <= '0;
      wdog <= '0;
      clr_cnt <= '0;
      over_q <= 1'b0;
      ctl.load <= 1'b0;
      ctl.running <= 1'b0;
      ctl.dp_clear <= 1'b0;
      ctl.busy <= 1'b0;
      ctl.job_done <= 1'b0;
      ctl.timeout_err <= 1'b0;
      ctl.job_count <= '0;
      ctl.state_dbg <= 3'd0;
    end else begin
      state <= nxt;
      over_q <= ctl.over;
      byte_cnt <= state == LOAD ? byte_cnt + BC_W'(ctl.nextByte_in) : '0;
      wdog <= (!active || nxt != state || (state == LOAD && ctl.nextByte_in)) ? '0 : wdog + 1'b1;
      clr_cnt <= state == FLUSH ? clr_cnt + 1'b1 : '0;
      ctl.load <= nxt == LOAD;
      ctl.running <= nxt == RUN;
      ctl.dp_clear <= nxt == FLUSH;
      ctl.busy <= nxt != IDLE;
      ctl.job_done <= nxt == DONE;
      ctl.job_count <= ctl.job_count + CNT_W'(nxt == DONE);
      ctl.timeout_err <= tmo | (ctl.timeout_err & ~ctl.err_clr);
      ctl.state_dbg <= nxt;
    end
  end
endmodule

// File: tb/tb_rsa_job_ctrl.sv
// tb_rsa_job_ctrl: directed checks of the RSA job controller (TIMEOUT_CYC=16, CNT_W=2)
module tb_rsa_job_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  rsa_job_ctrl_if #(.CNT_W(2)) b();
  rsa_job_ctrl #(.WordSize(32), .TIMEOUT_CYC(16), .CLEAR_CYC(2), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .ctl(b)
  );
  always #5 clk = ~clk;
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic to_run();
    b.enable = 1'b1;
    cyc(1);
    b.enable = 1'b0;
    b.nextByte_in = 1'b1;
    cyc(12);
    b.nextByte_in = 1'b0;
    chk("to_run_state", 32'(b.state_dbg), 2);
  endtask
  task automatic full_job();
    to_run();
    b.over = 1'b1;
    cyc(1);
    b.over = 1'b0;
    chk("job_done_pulse", 32'(b.job_done), 1);
    cyc(1);
  endtask
  initial begin
    b.enable = 0; b.abort = 0; b.err_clr = 0; b.empty_fifo = 1; b.nextByte_in = 0; b.over = 0;
    cyc(2);
    chk("rst_state", 32'(b.state_dbg), 0);
    chk("rst_busy", 32'(b.busy), 0);
    chk("rst_count", 32'(b.job_count), 0);
    chk("rst_err", 32'(b.timeout_err), 0);
    reset = 1'b1;
    cyc(1);
    // T1 nominal job with spaced bytes
    b.empty_fifo = 0; b.enable = 1;
    cyc(1);
    b.enable = 0;
    chk("t1_load_state", 32'(b.state_dbg), 1);
    chk("t1_load", 32'(b.load), 1);
    chk("t1_busy", 32'(b.busy), 1);
    for (int i = 0; i < 11; i++) begin
      b.nextByte_in = 1; cyc(1); b.nextByte_in = 0; cyc(1);
    end
    chk("t1_load_11", 32'(b.load), 1);
    b.nextByte_in = 1; cyc(1); b.nextByte_in = 0;
    chk("t1_run_state", 32'(b.state_dbg), 2);
    chk("t1_load_off", 32'(b.load), 0);
    chk("t1_running", 32'(b.running), 1);
    cyc(9);
    chk("t1_still_run", 32'(b.running), 1);
    b.over = 1; cyc(1);
    chk("t1_done_state", 32'(b.state_dbg), 3);
    chk("t1_job_done", 32'(b.job_done), 1);
    chk("t1_count", 32'(b.job_count), 1);
    cyc(1); b.over = 0;
    chk("t1_idle", 32'(b.state_dbg), 0);
    chk("t1_done_low", 32'(b.job_done), 0);
    chk("t1_busy_low", 32'(b.busy), 0);
    // T2 load timeout
    b.enable = 1; cyc(1); b.enable = 0;
    b.nextByte_in = 1; cyc(5); b.nextByte_in = 0;
    cyc(15);
    chk("t2_pre_tmo", 32'(b.state_dbg), 1);
    chk("t2_pre_err", 32'(b.timeout_err), 0);
    cyc(1);
    chk("t2_flush", 32'(b.state_dbg), 4);
    chk("t2_dpclr1", 32'(b.dp_clear), 1);
    chk("t2_err", 32'(b.timeout_err), 1);
    chk("t2_load_off", 32'(b.load), 0);
    cyc(1);
    chk("t2_dpclr2", 32'(b.dp_clear), 1);
    cyc(1);
    chk("t2_idle", 32'(b.state_dbg), 0);
    chk("t2_dpclr_off", 32'(b.dp_clear), 0);
    b.enable = 1; cyc(3);
    chk("t2_blocked", 32'(b.state_dbg), 0);
    b.err_clr = 1; cyc(1); b.err_clr = 0;
    chk("t2_err_clr", 32'(b.timeout_err), 0);
    cyc(1); b.enable = 0;
    chk("t2_restart", 32'(b.state_dbg), 1);
    b.abort = 1; cyc(1); b.abort = 0;
    chk("t2_abort_load", 32'(b.state_dbg), 4);
    cyc(2);
    chk("t2_abort_idle", 32'(b.state_dbg), 0);
    // T3 abort in RUN, then abort together with over_rise
    to_run();
    b.abort = 1; cyc(1); b.abort = 0;
    chk("t3_flush", 32'(b.state_dbg), 4);
    chk("t3_dpclr", 32'(b.dp_clear), 1);
    chk("t3_run_off", 32'(b.running), 0);
    cyc(1);
    chk("t3_dpclr2", 32'(b.dp_clear), 1);
    cyc(1);
    chk("t3_idle", 32'(b.state_dbg), 0);
    chk("t3_err", 32'(b.timeout_err), 0);
    chk("t3_count", 32'(b.job_count), 1);
    to_run();
    b.over = 1; b.abort = 1; cyc(1); b.over = 0; b.abort = 0;
    chk("t3_ab_ov_state", 32'(b.state_dbg), 4);
    chk("t3_ab_ov_done", 32'(b.job_done), 0);
    cyc(2);
    chk("t3_ab_ov_count", 32'(b.job_count), 1);
    // T4 over held high into RUN needs a fresh edge
    b.over = 1;
    to_run();
    cyc(3);
    chk("t4_held_over", 32'(b.state_dbg), 2);
    b.over = 0; cyc(1);
    chk("t4_over_fall", 32'(b.state_dbg), 2);
    b.over = 1; cyc(1); b.over = 0;
    chk("t4_fresh_done", 32'(b.state_dbg), 3);
    chk("t4_count2", 32'(b.job_count), 2);
    cyc(1);
    // watchdog and over_rise in the same cycle complete the job
    to_run();
    cyc(15);
    chk("t4_wd_pre", 32'(b.state_dbg), 2);
    b.over = 1; cyc(1); b.over = 0;
    chk("t4_wd_done", 32'(b.state_dbg), 3);
    chk("t4_wd_noerr", 32'(b.timeout_err), 0);
    chk("t4_count3", 32'(b.job_count), 3);
    cyc(1);
    full_job();
    chk("t4_wrap0", 32'(b.job_count), 0);
    full_job();
    chk("t4_wrap1", 32'(b.job_count), 1);
    // T5 asynchronous reset mid-LOAD
    b.enable = 1; cyc(1); b.enable = 0;
    b.nextByte_in = 1; cyc(3); b.nextByte_in = 0;
    chk("t5_in_load", 32'(b.load), 1);
    #2 reset = 0;
    #1;
    chk("t5_state", 32'(b.state_dbg), 0);
    chk("t5_load", 32'(b.load), 0);
    chk("t5_busy", 32'(b.busy), 0);
    chk("t5_count", 32'(b.job_count), 0);
    #1 reset = 1;
    cyc(1);
    full_job();
    chk("t5_after_count", 32'(b.job_count), 1);
    chk("t5_after_idle", 32'(b.state_dbg), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
